// File: rtl/rr_sched_pkg.sv
// Shared types, default sizes and the rotating priority search
// used by the round-robin grant scheduler.
package rr_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int unsigned N_DEF        = 16;
    localparam int unsigned MAX_HOLD_DEF = 8;

    // Widest request vector next_winner() can search.
    localparam int unsigned N_MAX = 64;

    // First set bit of req at or after start, wrapping modulo n.
    // Returns 0 when req has no bit set in [0, n).
    function automatic int unsigned next_winner(
        input logic [N_MAX-1:0] req,
        input int unsigned      start,
        input int unsigned      n
    );
        int unsigned win;
        int unsigned j;
        logic        found;
        win   = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < N_MAX; k++) begin
            j = (start + k) % n;
            if (!found && k < n && req[j[5:0]]) begin
                win   = j;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_grant_scheduler_dec.sv
// Binary-to-one-hot decoder.
// Ports: idx_i (binary index in), onehot_o (exactly one bit set out).
module rr_grant_scheduler_dec
    import rr_sched_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic [$clog2(N)-1:0] idx_i,
    output logic [N-1:0]         onehot_o
);

    always_comb begin
        onehot_o        = '0;
        onehot_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin arbiter: one owner holds the resource until it
// releases; the next owner is searched from the old owner + 1.
// Ports: clk, rst (sync, active-high), req[N], release_i (owner
// done pulse; "release" is a reserved word), grant[N] one-hot,
// grant_idx binary owner, grant_valid, timeout preemption pulse.
// Macro ARB_TIMEOUT_EN: preempt an owner after MAX_HOLD cycles
// when someone else is waiting; otherwise timeout is tied to 0.
module rr_grant_scheduler
    import rr_sched_pkg::*;
#(
    parameter int unsigned N        = N_DEF,
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 release_i,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 grant_valid,
    output logic                 timeout
);

    localparam int unsigned IW = $clog2(N);

    if (N < 2 || N > N_MAX || (N & (N - 1)) != 0 || MAX_HOLD < 2)
    begin : g_bad_param
        $error("rr_grant_scheduler: illegal N or MAX_HOLD");
    end

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  own_oh;
    logic [IW-1:0] win;
    int unsigned   start;
    logic          rel;
    logic          preempt;
    logic          handoff;

    rr_grant_scheduler_dec #(
        .N (N)
    ) u_dec (
        .idx_i    (idx_q),
        .onehot_o (own_oh)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_SAT = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          to_q;

    // Only preempt when somebody else is actually waiting;
    // a lone owner keeps the grant with hold_q saturated.
    always_comb begin
        preempt = (state_q == GRANT) && !rel &&
                  (hold_q == HOLD_SAT) && |(req & ~own_oh);
    end

    always_comb begin
        hold_d = hold_q;
        if (state_q == IDLE || handoff) begin
            hold_d = '0;
        end else if (hold_q != HOLD_SAT) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            to_q   <= 1'b0;
        end else begin
            hold_q <= hold_d;
            to_q   <= preempt;
        end
    end

    assign timeout = to_q;
`else
    assign preempt = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        rel     = (state_q == GRANT) && (release_i || !req[idx_q]);
        handoff = rel || preempt;
        // Searching from owner+1 makes the old owner the last
        // candidate, so it only wins again when it is alone.
        start   = (state_q == GRANT) ? 32'(idx_q) + 1
                                     : 32'(ptr_q) + 1;
        win     = IW'(next_winner(N_MAX'(req), start, N));

        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    idx_d   = win;
                end
            end
            GRANT: begin
                if (handoff) begin
                    ptr_d = idx_q;
                    if (|req) begin
                        idx_d = win;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= IW'(N - 1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_valid = (state_q == GRANT);
    assign grant_idx   = idx_q;
    assign grant       = own_oh & {N{grant_valid}};

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler: reference model of the
// arbitration rules plus literal checks on the key scenarios.
module tb_rr_grant_scheduler;

    localparam int N  = 16;
    localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        release_i;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        timeout;

    always #5 clk = ~clk;

    rr_grant_scheduler #(
        .N        (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .release_i   (release_i),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: owner = -1 when idle.
    int m_owner = -1;
    int m_ptr   = N - 1;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    function automatic int search(logic [15:0] r, int from);
        int order[$];
        for (int k = 0; k < N; k++) order.push_back((from + k) % N);
        foreach (order[i]) if (r[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic model_step();
        bit released, pre;
        int others;
        if (rst) begin
            m_owner = -1; m_ptr = N - 1; m_hold = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            if (req != 0) begin
                m_owner = search(req, m_ptr + 1);
                m_hold  = 0;
            end
        end else begin
            released = release_i || !req[m_owner];
            others   = 0;
            for (int i = 0; i < N; i++)
                if (i != m_owner && req[i]) others++;
            pre = TO_EN && !released && m_hold >= MH - 1 && others > 0;
            if (released || pre) begin
                m_ptr   = m_owner;
                m_owner = (req != 0) ? search(req, m_owner + 1) : -1;
                m_hold  = 0;
                m_to    = pre;
            end else begin
                m_hold = (m_hold + 1 > MH - 1) ? MH - 1 : m_hold + 1;
                m_to   = 1'b0;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [15:0] eg;
        @(posedge clk);
        model_step();
        #1;
        eg = (m_owner >= 0) ? (16'h1 << m_owner) : 16'h0;
        chk("model_grant", 32'(grant), 32'(eg));
        chk("model_idx", 32'(grant_idx),
            32'((m_owner >= 0) ? m_owner : 0));
        chk("model_valid", 32'(grant_valid), 32'(m_owner >= 0));
        chk("model_timeout", 32'(timeout), 32'(m_to));
    endtask

    logic [15:0] pats [6] = '{16'hA5A5, 16'h0001, 16'h8000,
                              16'h00F0, 16'hFFFF, 16'h0000};

    initial begin
        rst = 1'b1; req = 16'hFFFF; release_i = 1'b0;

        // Reset with everyone requesting.
        tick(); chk("rst_grant", 32'(grant), 32'h0);
        tick(); chk("rst_valid", 32'(grant_valid), 32'h0);
        chk("rst_idx", 32'(grant_idx), 32'h0);
        rst = 1'b0;
        tick(); chk("first_grant", 32'(grant), 32'h0001);
        chk("first_idx", 32'(grant_idx), 32'h0);

        // Single requester.
        req = 16'h0000; tick();
        req = 16'h0020; tick();
        chk("single_grant", 32'(grant), 32'h0020);
        chk("single_idx", 32'(grant_idx), 32'd5);
        req = 16'h0000; tick();
        chk("single_drop", 32'(grant_valid), 32'h0);

        // Fairness and wrap from a fresh pointer.
        rst = 1'b1; tick(); rst = 1'b0;
        req = 16'h8003; tick();
        chk("rr_0", 32'(grant_idx), 32'd0);
        release_i = 1'b1; tick(); chk("rr_1", 32'(grant_idx), 32'd1);
        release_i = 1'b0; tick();
        release_i = 1'b1; tick(); chk("rr_15", 32'(grant_idx), 32'd15);
        release_i = 1'b0; tick();
        release_i = 1'b1; tick(); chk("rr_0b", 32'(grant_idx), 32'd0);
        release_i = 1'b0; tick();
        release_i = 1'b1; tick(); chk("rr_1b", 32'(grant_idx), 32'd1);
        chk("rr_valid", 32'(grant_valid), 32'h1);
        release_i = 1'b0;

        // Sole owner re-granted without a gap.
        req = 16'h0004; tick(); chk("sole_idx", 32'(grant_idx), 32'd2);
        release_i = 1'b1; tick();
        chk("sole_regrant", 32'(grant_idx), 32'd2);
        chk("sole_valid", 32'(grant_valid), 32'h1);
        release_i = 1'b0; tick();

        // Reset mid-grant.
        req = 16'h0008; tick(); chk("mid_idx3", 32'(grant_idx), 32'd3);
        rst = 1'b1; req = 16'h0009; tick();
        chk("mid_rst_grant", 32'(grant), 32'h0);
        rst = 1'b0; tick();
        chk("mid_after_idx", 32'(grant_idx), 32'd0);

        // Release while idle is ignored.
        req = 16'h0000; tick();
        release_i = 1'b1; tick();
        chk("idle_release", 32'(grant_valid), 32'h0);
        release_i = 1'b0;

        // Hold limit.
        rst = 1'b1; tick(); rst = 1'b0;
        req = 16'h0003; tick(); chk("hold_idx0", 32'(grant_idx), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("hold_keep", 32'(grant_idx), 32'd0);
        end
        tick();
        chk("hold_next_idx", 32'(grant_idx), TO_EN ? 32'd1 : 32'd0);
        chk("hold_to_pulse", 32'(timeout), TO_EN ? 32'd1 : 32'd0);
        tick(); chk("hold_to_low", 32'(timeout), 32'h0);
        req = 16'h0001;
        for (int i = 0; i < 10; i++) tick();
        chk("lone_idx", 32'(grant_idx), 32'd0);
        chk("lone_to", 32'(timeout), 32'h0);

        // Mixed patterns checked against the model.
        foreach (pats[p]) begin
            req = pats[p];
            for (int c = 0; c < 8; c++) begin
                release_i = (c % 3 == 2);
                tick();
            end
        end
        release_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Round-robin arbiter that shares one resource among N requesters.
- Grants ownership in binary form (grant_idx) and one-hot form (grant). The one-hot form comes from the team's existing binary-to-one-hot decoder.
- Sits in front of any N-way shared datapath (bus, register port, functional unit). The owner keeps the grant until it releases it.

Parameters:
- N, 16, number of requesters; N >= 2, power of two.
- MAX_HOLD, 8, maximum number of cycles one owner may hold the grant while others wait. Used only with ARB_TIMEOUT_EN; MAX_HOLD >= 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N  request vector; bit i is high while requester i wants the resource.
- release  input  1  single-cycle pulse from the current owner meaning "done".
- grant  output  N  one-hot grant; all zero when grant_valid=0.
- grant_idx  output  $clog2(N)  binary index of the owner; 0 when idle.
- grant_valid  output  1  high while a grant is active.
- timeout  output  1  single-cycle preemption pulse; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset values:
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - state=IDLE; priority pointer ptr=N-1, so the first search starts at requester 0.
  - hold_cnt=0.
- Reset mid-grant drops the grant on the next edge. No release handshake is generated.
- State IDLE:
  - If |req=1, register the winner and go to GRANT.
  - Latency from req to grant is 1 cycle.
  - Winner = first set bit of req, searching ptr+1, ptr+2, ... modulo N. The search wraps from N-1 to 0.
- State GRANT:
  - The owner is held while req[grant_idx]=1 and release=0.
  - Requests from other requesters are ignored during this time. They stay pending; the scheduler queues nothing itself.
- Release condition: release=1, OR req[grant_idx]=0 (the owner dropped its request). Both in the same cycle count as one release. On release:
  - ptr <= grant_idx.
  - The same edge re-arbitrates over the current req, searching from grant_idx+1. Back-to-back grants therefore have no idle cycle.
  - The old owner is the last candidate. It is re-granted only if it is the sole requester and still has its req bit high.
  - If no request remains, go to IDLE with grant_valid=0.
- A release pulse while grant_valid=0 is ignored.
- grant = decoder(grant_idx) AND {N{grant_valid}}. It is registered and changes only on clock edges; at most one bit is set.
- hold_cnt:
  - Set to 0 on every new grant.
  - Increments each GRANT cycle.
  - Saturates at MAX_HOLD-1.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - When hold_cnt = MAX_HOLD-1, no release occurs, and another requester is pending, the owner is preempted on that edge as if it had released.
  - timeout pulses high for 1 cycle, aligned with the new grant.
  - The owner therefore holds the grant for exactly MAX_HOLD cycles.
  - If no other requester is pending, the grant is kept and hold_cnt stays saturated.
- Without the macro: no preemption, timeout=0, and hold_cnt logic is compiled out.

Decomposition:
- Package rr_sched_pkg holds:
  - the state enum state_t {IDLE, GRANT};
  - the default N and MAX_HOLD constants;
  - a function next_winner(req, start) returning the index of the first set bit from start, with wrap-around.
- Sub-module: the existing decoder, with parameter N, converting the registered grant_idx to one-hot. No other sub-modules.

Test Plan:
- Reset: rst=1 for 2 cycles with req=16'hFFFF -> grant=16'h0000, grant_idx=0, grant_valid=0 throughout. After rst drops, the next edge gives grant=16'h0001, grant_idx=0.
- Single requester: req=16'h0020 -> one cycle later grant=16'h0020, grant_idx=5, grant_valid=1. Drop req -> next edge grant=0, grant_valid=0.
- Fairness and wrap: req=16'h8003 held, release pulsed once per grant -> grant_idx sequence 0,1,15,0,1 with no idle cycles.
- Sole owner re-grant: req=16'h0004 held, release pulsed -> grant_idx stays 2 with grant_valid continuously 1.
- Reset mid-grant: grant_idx=3 active, rst=1 for 1 cycle with req=16'h0009 -> grant=0 after that edge. The next edge grants grant_idx=0, because the pointer was reset.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=16'h0003, no release -> grant_idx=0 for exactly 4 cycles, then grant_idx=1 with timeout=1 for 1 cycle. With req=16'h0001 only, the grant holds indefinitely and timeout stays 0.
